// File: rtl/vm2002_change_dispenser.sv
// vm2002 change dispenser: pays a balance out greedily as quarters, dimes and
// nickels, limited by on-board inventory, and reports what could not be paid.
//
// Handshake: coin_valid/coin_out are raised together and held unchanged until
// the hopper answers with coin_ack in a cycle where coin_valid is high. The
// coin counts as taken on that edge, and coin_valid drops on the next cycle.
// coin_ack is ignored whenever no coin is being offered.
//
// state_dbg is an additional output that shows the current FSM state.
module vm2002_change_dispenser #(
  parameter int Q_VAL = 25,
  parameter int D_VAL = 10,
  parameter int N_VAL = 5,
  parameter int INV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      amount,
  input  logic             load,
  input  logic [1:0]       load_sel,
  input  logic [INV_W-1:0] load_count,
  input  logic             coin_ack,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      residual,
  output logic [INV_W-1:0] q_cnt,
  output logic [INV_W-1:0] d_cnt,
  output logic [INV_W-1:0] n_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] Q16 = 16'(Q_VAL);
  localparam logic [15:0] D16 = 16'(D_VAL);
  localparam logic [15:0] N16 = 16'(N_VAL);

  state_t           state, state_n;
  logic [15:0]      remaining, remaining_n;
  logic [1:0]       coin_out_n;
  logic             coin_valid_n, done_n, busy_n;
  logic [15:0]      residual_n;
  logic             dec_q, dec_d, dec_n;
  logic [INV_W-1:0] q_next, d_next, n_next;

  // Cents represented by a coin code.
  function automatic logic [15:0] coin_value(input logic [1:0] c);
    case (c)
      2'b11:   coin_value = Q16;
      2'b10:   coin_value = D16;
      2'b01:   coin_value = N16;
      default: coin_value = 16'd0;
    endcase
  endfunction

  // Restock add that clamps at the counter's maximum instead of wrapping.
  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] cnt,
                                               input logic [INV_W-1:0] add);
    logic [INV_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, add};
    sat_add = sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
  endfunction

  // Next-state and next-output logic of the payout FSM.
  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    coin_out_n   = coin_out;
    coin_valid_n = coin_valid;
    done_n       = 1'b0;
    residual_n   = residual;
    dec_q        = 1'b0;
    dec_d        = 1'b0;
    dec_n        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_n = amount;
          state_n     = SELECT;
        end
      end
      SELECT: begin
        if (remaining >= Q16 && q_cnt != '0) begin
          coin_out_n   = 2'b11;
          coin_valid_n = 1'b1;
          state_n      = OFFER;
        end else if (remaining >= D16 && d_cnt != '0) begin
          coin_out_n   = 2'b10;
          coin_valid_n = 1'b1;
          state_n      = OFFER;
        end else if (remaining >= N16 && n_cnt != '0) begin
          coin_out_n   = 2'b01;
          coin_valid_n = 1'b1;
          state_n      = OFFER;
        end else begin
          done_n     = 1'b1;
          residual_n = remaining;
          state_n    = DONE;
        end
      end
      OFFER: begin
        if (coin_ack) begin
          coin_valid_n = 1'b0;
          coin_out_n   = 2'b00;
          remaining_n  = remaining - coin_value(coin_out);
          dec_q        = (coin_out == 2'b11);
          dec_d        = (coin_out == 2'b10);
          dec_n        = (coin_out == 2'b01);
          state_n      = SELECT;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Inventory update: restock (saturating) first, then remove the acked coin.
  always_comb begin
    q_next = (load && load_sel == 2'b11) ? sat_add(q_cnt, load_count) : q_cnt;
    d_next = (load && load_sel == 2'b10) ? sat_add(d_cnt, load_count) : d_cnt;
    n_next = (load && load_sel == 2'b01) ? sat_add(n_cnt, load_count) : n_cnt;
    q_next = q_next - {{(INV_W-1){1'b0}}, dec_q};
    d_next = d_next - {{(INV_W-1){1'b0}}, dec_d};
    n_next = n_next - {{(INV_W-1){1'b0}}, dec_n};
  end

  // State, datapath and output registers; reset aborts any payout in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= 16'd0;
      coin_out   <= 2'b00;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      residual   <= 16'd0;
      q_cnt      <= '0;
      d_cnt      <= '0;
      n_cnt      <= '0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      coin_out   <= coin_out_n;
      coin_valid <= coin_valid_n;
      busy       <= busy_n;
      done       <= done_n;
      residual   <= residual_n;
      q_cnt      <= q_next;
      d_cnt      <= d_next;
      n_cnt      <= n_next;
    end
  end

  assign state_dbg = state;

endmodule
